// File: rtl/phys_reg_freelist_pkg.sv
// Shared rename-path parameters and the popcount helper used by the free list,
// dispatch and the RS banks.
package phys_reg_freelist_pkg;

  localparam int unsigned DefDispatchWidth = 3;
  localparam int unsigned DefPhysRegs      = 64;
  localparam int unsigned DefArchRegs      = 32;

  // Callers zero-extend narrower vectors to this width.
  localparam int unsigned PopMaxW = 256;

  function automatic int unsigned popcount(input logic [PopMaxW-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < PopMaxW; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/nth_free_select.sv
// Picks the k-th lowest set bit of a bitmap (k counted from zero) as a one-hot,
// with a flag telling whether the bitmap has more than k set bits.
module nth_free_select #(
  parameter int unsigned Width = 64,
  // Must be wide enough to hold Width itself.
  parameter int unsigned KW    = 7
) (
  input  logic [Width-1:0] bitmap_i,
  input  logic [KW-1:0]    k_i,
  output logic [Width-1:0] onehot_o,
  output logic             found_o
);

  logic [KW-1:0] seen;

  always_comb begin
    onehot_o = '0;
    found_o  = 1'b0;
    seen     = '0;
    for (int b = 0; b < Width; b++) begin
      if (bitmap_i[b]) begin
        if (!found_o && (seen == k_i)) begin
          onehot_o[b] = 1'b1;
          found_o     = 1'b1;
        end
        seen = seen + KW'(1);
      end
    end
  end

endmodule

// File: rtl/phys_reg_freelist.sv
// R10K physical-register free list: compacted per-slot grants, retirement-state
// copy for reclaiming Told, and restore of the speculative list on mispredict.
module phys_reg_freelist
  import phys_reg_freelist_pkg::*;
#(
  parameter int unsigned N         = DefDispatchWidth,
  parameter int unsigned PHYS_REGS = DefPhysRegs,
  parameter int unsigned ARCH_REGS = DefArchRegs,
  localparam int unsigned TAG      = $clog2(PHYS_REGS),
  localparam int unsigned CNT_W    = $clog2(PHYS_REGS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N-1:0]                  free_alloc_valid,
  output logic [N-1:0][PHYS_REGS-1:0]   granted_regs,
  output logic [CNT_W-1:0]              freelist_free_slots,
  input  logic [N-1:0]                  retire_valid,
  input  logic [N-1:0][TAG-1:0]         retire_phys_rd,
  input  logic [N-1:0][TAG-1:0]         retire_told,
  input  logic                          mispredict
);

  logic [PHYS_REGS-1:0] spec_free_q, spec_free_d;
  logic [PHYS_REGS-1:0] arch_free_q, arch_free_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PHYS_REGS-1:0] reset_map;

  logic [N-1:0][CNT_W-1:0]     slot_k;
  logic [CNT_W-1:0]            req_total;
  logic [N-1:0][PHYS_REGS-1:0] sel_onehot;
  logic [N-1:0]                sel_found;
  logic [PHYS_REGS-1:0]        grant_mask;
  logic [PHYS_REGS-1:0]        told_mask;

  // Architectural registers start mapped; everything above them is free.
  always_comb begin
    reset_map = '0;
    for (int b = ARCH_REGS; b < PHYS_REGS; b++) begin
      reset_map[b] = 1'b1;
    end
  end

  // Slot i asks for the k-th free register, k = requests in lower slots.
  always_comb begin
    req_total = '0;
    for (int i = 0; i < N; i++) begin
      slot_k[i] = req_total;
      if (free_alloc_valid[i]) req_total = req_total + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_sel
    nth_free_select #(
      .Width (PHYS_REGS),
      .KW    (CNT_W)
    ) u_sel (
      .bitmap_i (spec_free_q),
      .k_i      (slot_k[i]),
      .onehot_o (sel_onehot[i]),
      .found_o  (sel_found[i])
    );
  end

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < N; i++) begin
      granted_regs[i] = '0;
      if (!reset && free_alloc_valid[i] && sel_found[i]) begin
        granted_regs[i] = sel_onehot[i];
        grant_mask      = grant_mask | sel_onehot[i];
      end
    end
  end

  assign freelist_free_slots = reset ? '0 : count_q;

  always_comb begin
    arch_free_d = arch_free_q;
    told_mask   = '0;
    // Slot order matters: a later Told may re-free an earlier slot's new mapping.
    for (int i = 0; i < N; i++) begin
      if (retire_valid[i]) begin
        arch_free_d[retire_phys_rd[i]] = 1'b0;
        if (retire_told[i] != '0) begin
          arch_free_d[retire_told[i]] = 1'b1;
          told_mask[retire_told[i]]   = 1'b1;
        end
      end
    end

    if (mispredict) begin
      spec_free_d = arch_free_d;
    end else begin
      spec_free_d = (spec_free_q & ~grant_mask) | told_mask;
    end

    spec_free_d[0] = 1'b0;
    arch_free_d[0] = 1'b0;
    count_d        = CNT_W'(popcount(PopMaxW'(spec_free_d)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_free_q <= reset_map;
      arch_free_q <= reset_map;
      count_q     <= CNT_W'(PHYS_REGS - ARCH_REGS);
    end else begin
      spec_free_q <= spec_free_d;
      arch_free_q <= arch_free_d;
      count_q     <= count_d;
    end
  end

  // Protocol checks: dispatch must not over-request, retire must not double-free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (req_total <= count_q)
        else $warning("phys_reg_freelist: %0d allocs requested, %0d free", req_total, count_q);
      for (int i = 0; i < N; i++) begin
        if (retire_valid[i] && (retire_told[i] != '0)) begin
          assert (!spec_free_q[retire_told[i]])
            else $warning("phys_reg_freelist: p%0d freed while already free", retire_told[i]);
        end
      end
    end
  end

endmodule
